cheshire_xilinx_rst_seq: RTL and testbench

FPGA bring-up reset sequencer for the Cheshire Xilinx top. It sits between the board reset, clock-wizard lock and DDR MIG calibration status on one side and the SoC, USB and DRAM-wrapper resets on the other. It releases these resets in a fixed order, latches the boot mode at SoC reset release, and re-sequences on clock-lock loss, calibration loss or a software/VIO reset request.

---
 rtl/cheshire_xilinx_rst_seq_if.sv | 23 ++
 rtl/cheshire_xilinx_rst_seq.sv | 140 ++++++++++++++
 tb/tb_cheshire_xilinx_rst_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cheshire_xilinx_rst_seq_if.sv
// Signal bundle between the Cheshire reset sequencer (slave) and the board/SoC environment (master).
interface cheshire_xilinx_rst_seq_if;
   logic       clk_locked_i;
   logic       calib_done_i;
   logic       sw_rst_req_i;
   logic [1:0] boot_mode_i;
   logic       dram_rst_o;
   logic       usb_rst_no;
   logic       soc_rst_no;
   logic [1:0] boot_mode_o;
   logic [2:0] state_o;
   logic       fail_o;

   modport slave (
      input  clk_locked_i, calib_done_i, sw_rst_req_i, boot_mode_i,
      output dram_rst_o, usb_rst_no, soc_rst_no, boot_mode_o, state_o, fail_o
   );

   modport master (
      output clk_locked_i, calib_done_i, sw_rst_req_i, boot_mode_i,
      input  dram_rst_o, usb_rst_no, soc_rst_no, boot_mode_o, state_o, fail_o
   );
endinterface

// File: rtl/cheshire_xilinx_rst_seq.sv
// Bring-up reset sequencer for the Cheshire Xilinx top: lock -> DRAM reset -> calibration -> SoC release.
// Define CHESHIRE_RSTSEQ_CALIB_TIMEOUT_EN to enable the calibration timeout into FAIL.
//
// state      | meaning
// IDLE       | one cycle after reset, all resets asserted
// WAIT_LOCK  | filtering clock-wizard lock
// DRAM_RST   | DRAM wrapper held in reset for a fixed time
// WAIT_CALIB | waiting for MIG calibration
// SOC_HOLD   | DRAM/USB released, SoC held in reset
// RUN        | everything released
// FAIL       | calibration timed out, all resets asserted
module cheshire_xilinx_rst_seq #(
   parameter int unsigned LockFilterCycles = 16,
   parameter int unsigned DramRstCycles    = 100,
   parameter int unsigned SocRstDelay      = 32,
   parameter int unsigned CalibTimeout     = 1048576
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   cheshire_xilinx_rst_seq_if.slave          rst_if
);

   localparam int unsigned MaxA = (LockFilterCycles > DramRstCycles) ? LockFilterCycles : DramRstCycles;
   localparam int unsigned MaxB = (SocRstDelay > CalibTimeout) ? SocRstDelay : CalibTimeout;
   localparam int unsigned MaxP = (MaxA > MaxB) ? MaxA : MaxB;
   localparam int unsigned CntW = $clog2(MaxP) + 1;

   localparam logic [CntW-1:0] LockLast = CntW'(LockFilterCycles - 1);
   localparam logic [CntW-1:0] DramLast = CntW'(DramRstCycles - 1);
   localparam logic [CntW-1:0] SocLast  = CntW'(SocRstDelay - 1);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
`ifdef CHESHIRE_RSTSEQ_CALIB_TIMEOUT_EN
   localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);
`endif

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_LOCK  = 3'd1,
      DRAM_RST   = 3'd2,
      WAIT_CALIB = 3'd3,
      SOC_HOLD   = 3'd4,
      RUN        = 3'd5,
      FAIL       = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        boot_q, boot_d;

   logic lock, calib, sw_req;
   assign lock   = rst_if.clk_locked_i;
   assign calib  = rst_if.calib_done_i;
   assign sw_req = rst_if.sw_rst_req_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         boot_q  <= boot_d;
      end
   end

   // Counter only advances while staying in a timed state; any transition leaves it at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      boot_d  = boot_q;
      case (state_q)
         IDLE: state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (!lock)                 cnt_d   = '0;
            else if (cnt_q == LockLast) state_d = DRAM_RST;
            else                        cnt_d   = cnt_q + CntOne;
         end
         DRAM_RST: begin
            if (!lock)                  state_d = WAIT_LOCK;
            else if (cnt_q == DramLast) state_d = WAIT_CALIB;
            else                        cnt_d   = cnt_q + CntOne;
         end
         WAIT_CALIB: begin
            if (!lock)      state_d = WAIT_LOCK;
            else if (calib) state_d = SOC_HOLD;
`ifdef CHESHIRE_RSTSEQ_CALIB_TIMEOUT_EN
            else if (cnt_q == CalibLast) state_d = FAIL;
            else                         cnt_d   = cnt_q + CntOne;
`endif
         end
         SOC_HOLD: begin
            if (!lock)       state_d = WAIT_LOCK;
            else if (!calib) state_d = DRAM_RST;
            // A request that is still high restarts the hold, so RUN follows only after it drops.
            else if (sw_req) cnt_d   = '0;
            else if (cnt_q == SocLast) begin
               state_d = RUN;
               boot_d  = rst_if.boot_mode_i;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         RUN: begin
            if (!lock)       state_d = WAIT_LOCK;
            else if (!calib) state_d = DRAM_RST;
            else if (sw_req) state_d = SOC_HOLD;
         end
         FAIL: begin
            if (sw_req) state_d = WAIT_LOCK;
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_comb begin
      rst_if.dram_rst_o = 1'b0;
      rst_if.usb_rst_no = 1'b0;
      rst_if.soc_rst_no = 1'b0;
      case (state_q)
         WAIT_LOCK, DRAM_RST, FAIL: rst_if.dram_rst_o = 1'b1;
         WAIT_CALIB:                rst_if.dram_rst_o = 1'b0;
         SOC_HOLD:                  rst_if.usb_rst_no = 1'b1;
         RUN: begin
            rst_if.usb_rst_no = 1'b1;
            rst_if.soc_rst_no = 1'b1;
         end
         default:                   rst_if.dram_rst_o = 1'b1;
      endcase
   end

   assign rst_if.boot_mode_o = boot_q;
   assign rst_if.state_o     = state_q;
`ifdef CHESHIRE_RSTSEQ_CALIB_TIMEOUT_EN
   assign rst_if.fail_o = (state_q == FAIL);
`else
   assign rst_if.fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_cheshire_xilinx_rst_seq.sv
// Self-checking bench for cheshire_xilinx_rst_seq: directed bring-up table, corner sequences, random run vs. model.
module tb_cheshire_xilinx_rst_seq;
   localparam int LF = 4;
   localparam int DR = 8;
   localparam int SD = 4;
   localparam int CT = 64;
`ifdef CHESHIRE_RSTSEQ_CALIB_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   cheshire_xilinx_rst_seq_if bus();

   cheshire_xilinx_rst_seq #(
      .LockFilterCycles(LF), .DramRstCycles(DR), .SocRstDelay(SD), .CalibTimeout(CT)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rst_if(bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: phase number plus time spent in it.
   int m_st = 0;
   int m_dw = 0;
   logic [1:0] m_bm = 2'b00;

   task automatic m_step();
      int nx;
      bit restart;
      if (rst_i) begin
         m_st = 0; m_dw = 0; m_bm = 2'b00;
         return;
      end
      nx = m_st;
      restart = 1'b0;
      if ((m_st inside {2, 3, 4, 5}) && !bus.clk_locked_i) nx = 1;
      else if ((m_st inside {4, 5}) && !bus.calib_done_i) nx = 2;
      else begin
         case (m_st)
            1: if (!bus.clk_locked_i) restart = 1'b1; else if (m_dw + 1 >= LF) nx = 2;
            2: if (m_dw + 1 >= DR) nx = 3;
            3: if (bus.calib_done_i) nx = 4; else if (TO && (m_dw + 1 >= CT)) nx = 6;
            4: if (bus.sw_rst_req_i) restart = 1'b1;
               else if (m_dw + 1 >= SD) begin nx = 5; m_bm = bus.boot_mode_i; end
            5: if (bus.sw_rst_req_i) nx = 4;
            6: if (bus.sw_rst_req_i) nx = 1;
            default: nx = 1;
         endcase
      end
      m_dw = (nx != m_st || restart) ? 0 : m_dw + 1;
      m_st = nx;
   endtask

   function automatic logic [6:0] exp_vec(int st);
      logic [2:0] s;
      s = st[2:0];
      return {s, st inside {0, 1, 2, 6}, st inside {4, 5}, st == 5, st == 6};
   endfunction

   function automatic logic [6:0] act_vec();
      return {bus.state_o, bus.dram_rst_o, bus.usb_rst_no, bus.soc_rst_no, bus.fail_o};
   endfunction

   task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      cyc = 0;
   endtask

   task automatic run_to(int c);
      while (cyc < c) tick();
   endtask

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic [1:0] bm;
   } vec_t;

   vec_t tbl[11];
   int lockp[4] = '{100, 98, 100, 95};
   int calp[4]  = '{90, 100, 0, 70};

   initial begin
      bus.clk_locked_i = 1'b1;
      bus.calib_done_i = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      bus.boot_mode_i  = 2'b01;

      tbl[0]  = '{0, 3'd0, 2'b00};  tbl[1]  = '{1, 3'd1, 2'b00};
      tbl[2]  = '{4, 3'd1, 2'b00};  tbl[3]  = '{5, 3'd2, 2'b00};
      tbl[4]  = '{12, 3'd2, 2'b00}; tbl[5]  = '{13, 3'd3, 2'b00};
      tbl[6]  = '{15, 3'd3, 2'b00}; tbl[7]  = '{16, 3'd4, 2'b00};
      tbl[8]  = '{19, 3'd4, 2'b00}; tbl[9]  = '{20, 3'd5, 2'b01};
      tbl[10] = '{21, 3'd5, 2'b01};

      // Clean bring-up, calibration on the third WAIT_CALIB cycle.
      do_reset();
      begin
         int r = 0;
         for (int c = 0; c <= 21; c++) begin
            bus.calib_done_i = (c >= 15);
            if (r < 11 && tbl[r].cyc == c) begin
               chk("bringup_out", act_vec(), exp_vec(int'(tbl[r].st)));
               chk("bringup_boot", {5'b0, bus.boot_mode_o}, {5'b0, tbl[r].bm});
               r++;
            end
            tick();
         end
      end

      // Lock glitch on the third WAIT_LOCK cycle.
      bus.calib_done_i = 1'b0;
      do_reset();
      run_to(3);
      bus.clk_locked_i = 1'b0;
      tick();
      bus.clk_locked_i = 1'b1;
      chk("glitch_wl4", act_vec(), exp_vec(1));
      run_to(7);
      chk("glitch_wl7", act_vec(), exp_vec(1));
      tick();
      chk("glitch_dram8", act_vec(), exp_vec(2));

      // Calibration never completes.
      do_reset();
      run_to(76);
      chk("timeout_wc76", act_vec(), exp_vec(3));
      tick();
      chk("timeout_fail77", act_vec(), exp_vec(TO ? 6 : 3));
      bus.sw_rst_req_i = 1'b1;
      tick();
      bus.sw_rst_req_i = 1'b0;
      chk("timeout_exit", act_vec(), exp_vec(TO ? 1 : 3));

      // Software reset request in RUN.
      bus.calib_done_i = 1'b1;
      bus.boot_mode_i  = 2'b01;
      do_reset();
      run_to(20);
      chk("sw_run_before", act_vec(), exp_vec(5));
      bus.boot_mode_i  = 2'b10;
      bus.sw_rst_req_i = 1'b1;
      tick();
      bus.sw_rst_req_i = 1'b0;
      for (int k = 0; k < SD; k++) begin
         chk("sw_hold", act_vec(), exp_vec(4));
         tick();
      end
      chk("sw_run_after", act_vec(), exp_vec(5));
      chk("sw_boot", {5'b0, bus.boot_mode_o}, 7'b0000010);

      // Lock loss and software request together in RUN.
      bus.clk_locked_i = 1'b0;
      bus.sw_rst_req_i = 1'b1;
      tick();
      bus.clk_locked_i = 1'b1;
      bus.sw_rst_req_i = 1'b0;
      chk("simul_wl", act_vec(), exp_vec(1));

      // Reset asserted while waiting for calibration.
      bus.calib_done_i = 1'b0;
      run_to(cyc + 14);
      chk("midrst_wc", act_vec(), exp_vec(3));
      chk("midrst_boot_pre", {5'b0, bus.boot_mode_o}, 7'b0000010);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midrst_out", act_vec(), exp_vec(0));
      chk("midrst_boot", {5'b0, bus.boot_mode_o}, 7'b0000000);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         int seg;
         seg = (i / 250) % 4;
         bus.clk_locked_i = ($urandom_range(0, 99) < lockp[seg]);
         bus.calib_done_i = ($urandom_range(0, 99) < calp[seg]);
         bus.sw_rst_req_i = ($urandom_range(0, 99) < 3);
         bus.boot_mode_i  = 2'($urandom_range(0, 3));
         rst_i            = ($urandom_range(0, 999) < 3);
         tick();
         chk("rand_out", act_vec(), exp_vec(m_st));
         chk("rand_boot", {5'b0, bus.boot_mode_o}, {5'b0, m_bm});
      end
      rst_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
